// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the byte-enable helper.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte enables for an access of the given size starting at byte lane 'lane'.
    // Size 3 enables nothing.
    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core (master) and the data memory (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_rw, req_wdata, req_size, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata, req_size, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane handling: byte-enable generation, store-data alignment and load
// extraction (right-aligned, zero-extended).
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic [31:0] rshift;

    // Lane shifts and size-dependent masking.
    always_comb begin
        be       = size_to_be(size, lane);
        wdata_sh = wdata << {lane, 3'b000};
        rshift   = rword >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: rdata = rshift & 32'h0000_00ff;
            SIZE_HALF: rdata = rshift & 32'h0000_ffff;
            SIZE_WORD: rdata = rword;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave with configurable latency, one request in flight.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
    input  logic       clock,
    input  logic       reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SpanB   = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        rw_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        req_ready;
    logic        accept;
    logic        enter_resp;
    logic        in_idle;
    logic [31:0] acc_addr, acc_wdata, offset;
    logic        acc_rw;
    logic [1:0]  acc_size;
    logic        misalign, in_range, acc_err;
    logic [IdxW-1:0] idx;
    logic [31:0] rword, wdata_sh, ext_rdata;
    logic [3:0]  be;
    logic        mem_we;

    assign accept     = bus.req_valid && req_ready;
    assign enter_resp = (state_q != RESP) && (state_d == RESP);
    assign in_idle    = (state_q == IDLE);

    // State and latency counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CntInit;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; req_ready is held low during reset.
    always_comb begin
        req_ready      = reset && in_idle;
        bus.req_ready  = req_ready;
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    // Capture the request on acceptance.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            rw_q    <= bus.req_rw;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
        end
    end

    // With LATENCY==1 RESP is entered on the acceptance edge itself, before the
    // capture registers hold the request, so the live bus is used in IDLE.
    always_comb begin
        acc_addr  = in_idle ? bus.req_addr  : addr_q;
        acc_rw    = in_idle ? bus.req_rw    : rw_q;
        acc_wdata = in_idle ? bus.req_wdata : wdata_q;
        acc_size  = in_idle ? bus.req_size  : size_q;
        offset    = acc_addr - BASE_ADDR;
        in_range  = (acc_addr >= BASE_ADDR) && (offset < SpanB);
        case (acc_size)
            SIZE_BYTE: misalign = 1'b0;
            SIZE_HALF: misalign = acc_addr[0];
            SIZE_WORD: misalign = (acc_addr[1:0] != 2'b00);
            default:   misalign = 1'b1;
        endcase
        acc_err = misalign || !in_range;
        idx     = offset[IdxW+1:2];
        rword   = mem[idx];
        mem_we  = enter_resp && reset && acc_rw && !acc_err;
    end

    dmem_lane_align u_align (
        .size     (acc_size),
        .lane     (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (rword),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ext_rdata)
    );

    // Storage write with per-byte merge; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // Response data and error, produced on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_rw) ? 32'd0 : ext_rdata;
        end
    end

endmodule
